// File: rtl/sequence_detector.sv
// Moore FSM that flags the serial pattern 1011 (first bit first) with a registered
// one-cycle pulse. OVERLAP selects whether a match's trailing bits may seed the next one.
module sequence_detector #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S1 : S2;
      S2:      state_d = in ? S3 : S0;
      S3:      state_d = in ? S4 : S2;
      // In overlap mode the trailing "10" of a following stream reuses the last '1'.
      S4:      state_d = in ? S1 : (OVERLAP ? S2 : S0);
      default: state_d = S0;
    endcase
  end

  assign out = (state_q == S4);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: one overlap and one non-overlap instance share
// the same stimulus and are compared against hand-computed expectations.
module tb_sequence_detector;

  logic clk;
  logic reset;
  logic in;
  logic out_ov1;
  logic out_ov0;

  int n_cmp;
  int n_bad;

  sequence_detector #(.OVERLAP(1'b1)) u_ov1 (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out_ov1)
  );

  sequence_detector #(.OVERLAP(1'b0)) u_ov0 (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out_ov0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  rst_n;
    logic  din;
    logic  exp1;
    logic  exp0;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic e1, input logic e0,
                     input string nm);
    vec_t v;
    v.rst_n = r;
    v.din   = d;
    v.exp1  = e1;
    v.exp0  = e0;
    v.name  = nm;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got out=%b, expected out=%b", nm, idx, act, exp);
    end
  endtask

  int pulses1;
  int pulses0;
  logic prev1;
  logic prev0;
  logic stream[10];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    in    = 1'b0;

    // Reset, then 1,1,0,1,1,1,1,0,0: only bit 5 completes 1011.
    add(0, 1, 0, 0, "rst_a");
    add(1, 1, 0, 0, "a"); add(1, 1, 0, 0, "a"); add(1, 0, 0, 0, "a");
    add(1, 1, 0, 0, "a"); add(1, 1, 1, 1, "a"); add(1, 1, 0, 0, "a");
    add(1, 1, 0, 0, "a"); add(1, 0, 0, 0, "a"); add(1, 0, 0, 0, "a");
    // Overlap stream 1,0,1,1,0,1,1: two pulses with overlap, one without.
    add(0, 0, 0, 0, "rst_b");
    add(1, 1, 0, 0, "ovl"); add(1, 0, 0, 0, "ovl"); add(1, 1, 0, 0, "ovl");
    add(1, 1, 1, 1, "ovl"); add(1, 0, 0, 0, "ovl"); add(1, 1, 0, 0, "ovl");
    add(1, 1, 1, 0, "ovl");
    // Reset while in the match state clears the flag.
    add(0, 1, 0, 0, "rst_in_s4");
    // Near miss 1,0,1,0,1,1: 1010 is not a hit, suffix 1011 is.
    add(1, 1, 0, 0, "near"); add(1, 0, 0, 0, "near"); add(1, 1, 0, 0, "near");
    add(1, 0, 0, 0, "near"); add(1, 1, 0, 0, "near"); add(1, 1, 1, 1, "near");
    // Near miss 1,0,0,1,1: no hit.
    add(0, 0, 0, 0, "rst_c");
    add(1, 1, 0, 0, "miss"); add(1, 0, 0, 0, "miss"); add(1, 0, 0, 0, "miss");
    add(1, 1, 0, 0, "miss"); add(1, 1, 0, 0, "miss");
    // Reset in S3 with in=1: progress lost, then a full 1011 is needed.
    add(0, 0, 0, 0, "rst_d");
    add(1, 1, 0, 0, "mid"); add(1, 0, 0, 0, "mid"); add(1, 1, 0, 0, "mid");
    add(0, 1, 0, 0, "mid_rst");
    add(1, 1, 0, 0, "mid"); add(1, 0, 0, 0, "mid"); add(1, 1, 0, 0, "mid");
    add(1, 1, 1, 1, "mid");
    // Reset held low across a full pattern never matches.
    add(0, 1, 0, 0, "hold"); add(0, 0, 0, 0, "hold"); add(0, 1, 0, 0, "hold");
    add(0, 1, 0, 0, "hold");
    // Long runs of ones then zeros.
    for (int i = 0; i < 20; i++) add(1, 1, 0, 0, "ones");
    for (int i = 0; i < 20; i++) add(1, 0, 0, 0, "zeros");
    // After the zeros the FSM must be in S0: 1011 matches with exact latency.
    add(1, 1, 0, 0, "post"); add(1, 0, 0, 0, "post"); add(1, 1, 0, 0, "post");
    add(1, 1, 1, 1, "post");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].din);
      check({vecs[i].name, "_ov1"}, i, out_ov1, vecs[i].exp1);
      check({vecs[i].name, "_ov0"}, i, out_ov0, vecs[i].exp0);
    end

    // Chained stream 1,0,1,1,0,1,1,0,1,1: count pulses and check none is wider than 1 cycle.
    stream = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    step(0, 0);
    pulses1 = 0;
    pulses0 = 0;
    prev1   = 1'b0;
    prev0   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, stream[i]);
      if (out_ov1 === 1'b1) pulses1++;
      if (out_ov0 === 1'b1) pulses0++;
      check("width_ov1", i, prev1 & out_ov1, 1'b0);
      check("width_ov0", i, prev0 & out_ov0, 1'b0);
      prev1 = out_ov1;
      prev0 = out_ov0;
    end
    n_cmp++;
    if (pulses1 != 3) begin
      n_bad++;
      $display("FAIL chain_count_ov1: got %0d pulses, expected 3", pulses1);
    end
    n_cmp++;
    if (pulses0 != 2) begin
      n_bad++;
      $display("FAIL chain_count_ov0: got %0d pulses, expected 2", pulses0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
